// File: rtl/pc_sequencer.sv
// Multicycle fetch/execute/commit controller owning PC, EPC and the EXL bit.
// Redirects on exception, misaligned target, eret and interrupt in fixed priority order.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        exec_done,
  input  logic [31:0] next_pc,
  input  logic        exception,
  input  logic        eret,
  input  logic        irq,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic        exl,
  output logic        exc_taken,
  output logic [1:0]  cause
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_IRQ   = 2'd1;
  localparam logic [1:0] CAUSE_EXC   = 2'd2;
  localparam logic [1:0] CAUSE_ALIGN = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] pc_q, epc_q, inst_q;
  logic        exl_q, exc_taken_q;
  logic [1:0]  cause_q;

  // Values captured from the datapath when it signals completion
  logic [31:0] npc_q;
  logic        exc_q, eret_q;

  logic [31:0] pc_d, epc_d;
  logic        exl_d, taken_d;
  logic [1:0]  cause_d;
  logic        misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem_ack)  state_d = S_EXEC;
      S_EXEC:   if (exec_done) state_d = S_COMMIT;
      S_COMMIT: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Commit decision; exl_q is the pre-update level, so nested traps keep epc
  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    exl_d      = exl_q;
    cause_d    = cause_q;
    taken_d    = 1'b0;
    misaligned = (npc_q[1:0] != 2'b00);
    if (exc_q || misaligned) begin
      pc_d    = EXC_VECTOR;
      cause_d = exc_q ? CAUSE_EXC : CAUSE_ALIGN;
      taken_d = 1'b1;
      if (!exl_q) begin
        epc_d = pc_q;
        exl_d = 1'b1;
      end
    end else if (eret_q) begin
      pc_d  = epc_q;
      exl_d = 1'b0;
    end else if (irq && !exl_q) begin
      epc_d   = npc_q;
      pc_d    = EXC_VECTOR;
      exl_d   = 1'b1;
      cause_d = CAUSE_IRQ;
      taken_d = 1'b1;
    end else begin
      pc_d = npc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      epc_q       <= 32'h0;
      exl_q       <= 1'b0;
      inst_q      <= 32'h0;
      exc_taken_q <= 1'b0;
      cause_q     <= 2'd0;
      npc_q       <= 32'h0;
      exc_q       <= 1'b0;
      eret_q      <= 1'b0;
    end else begin
      exc_taken_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (imem_ack) inst_q <= imem_rdata;
        end
        S_EXEC: begin
          if (exec_done) begin
            npc_q  <= next_pc;
            exc_q  <= exception;
            eret_q <= eret;
          end
        end
        S_COMMIT: begin
          pc_q        <= pc_d;
          epc_q       <= epc_d;
          exl_q       <= exl_d;
          cause_q     <= cause_d;
          exc_taken_q <= taken_d;
        end
        default: ;
      endcase
    end
  end

  assign imem_req   = (state_q == S_FETCH);
  assign inst_valid = (state_q == S_EXEC);
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign pc         = pc_q;
  assign epc        = epc_q;
  assign exl        = exl_q;
  assign exc_taken  = exc_taken_q;
  assign cause      = cause_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multicycle fetch/commit controller that owns the architectural PC, EPC and the exception-level (EXL) bit.
- Fetches each instruction over a req/ack instruction-memory handshake and presents it to the datapath.
- Waits for the datapath to finish the instruction, then commits the next PC supplied by the combinational next-PC calculator.
- Applies exception, misaligned-target, eret and interrupt redirection with fixed priority.
- Sits between instruction memory, the decoder/datapath and the next-PC logic.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
EXC_VECTOR, 32'h0040_0004, redirect target for every exception and interrupt.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, high throughout FETCH
imem_addr  out  32  fetch address, equals pc
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
inst  out  32  latched current instruction
inst_valid  out  1  high throughout EXEC
exec_done  in  1  datapath finished current instruction (sampled in EXEC only)
next_pc  in  32  sequential/branch/jump target from next-PC calculator
exception  in  1  synchronous exception raised by current instruction
eret  in  1  current instruction is eret
irq  in  1  level-sensitive external interrupt
pc  out  32  architectural PC of current instruction
epc  out  32  exception return address
exl  out  1  exception level; 1 = interrupts masked
exc_taken  out  1  one-cycle pulse in the cycle after a redirect commit
cause  out  2  last redirect cause: 0 none, 1 irq, 2 sync exception, 3 misaligned target

Behaviour:
- Reset (rst_n low, asynchronous): state=FETCH, pc=RESET_PC, epc=0, exl=0, inst=0, exc_taken=0, cause=0, internal latches cleared.
- Reset effect on outputs: inst_valid=0 and imem_req=1 (both decoded from state). Reset mid-fetch or mid-exec abandons the instruction; no commit occurs.
- FSM is three states, all registered; imem_req and inst_valid are decoded from state only.
- FETCH:
  - imem_req=1, imem_addr=pc, both stable until ack.
  - On imem_ack: inst<=imem_rdata, go to EXEC. An ack in the first FETCH cycle is legal.
- EXEC:
  - inst_valid=1.
  - On exec_done: latch next_pc, exception and eret into internal registers, go to COMMIT. An exec_done in the first EXEC cycle is legal.
- COMMIT: go to FETCH next cycle. Apply the first matching rule, using exl before update and the latched values:
  1. latched exception: pc<=EXC_VECTOR; if exl=0 then epc<=pc and exl<=1; cause<=2; exc_taken pulse.
  2. latched next_pc[1:0]!=0: same as rule 1 except cause<=3.
  3. latched eret: pc<=epc, exl<=0. irq is not taken in this commit.
  4. irq && exl=0: epc<=latched next_pc, pc<=EXC_VECTOR, exl<=1, cause<=1, exc_taken pulse.
  5. otherwise: pc<=latched next_pc.
- Nested exception (exl=1): redirect still occurs; epc is preserved.
- exc_taken is high exactly one cycle, coincident with the first FETCH cycle after a rule 1, 2 or 4 commit.
- cause holds its value until the next redirect.
- Minimum instruction period is 3 cycles (ack and done each arriving in the first cycle of their state).
- PC arithmetic is 32-bit with natural wrap; no range checking beyond alignment.
- irq arriving outside COMMIT is not lost while it stays asserted; it is level-sampled only in COMMIT.

Test Plan:
- Reset release, ack in the first FETCH cycle with rdata=32'h2008_0005, exec_done in the first EXEC cycle, next_pc=32'h4 -> imem_addr=0 for 1 cycle, inst=32'h2008_0005, pc=32'h4 after 3 cycles, second imem_req at addr 32'h4.
- Ack delayed 4 cycles -> imem_req held and imem_addr stable for 5 cycles; inst_valid stays 0 until the cycle after ack.
- pc=32'h10, exception=1 at exec_done -> pc=32'h0040_0004, epc=32'h10, exl=1, cause=2, exc_taken pulse of exactly 1 cycle.
- With exl=1 and epc=32'h10, eret=1 with irq=1 held -> pc=32'h10, exl=0, irq not taken. The next commit with next_pc=32'h14 gives epc=32'h14, pc=EXC_VECTOR, cause=1.
- pc=32'h20, next_pc=32'h0000_0022 -> pc=EXC_VECTOR, epc=32'h20, cause=3. A repeat of this with exl=1 leaves epc=32'h20.
- rst_n pulsed low during EXEC -> immediate state=FETCH, pc=RESET_PC, inst_valid=0, exl=0, with no commit of the in-flight instruction.
